// File: rtl/ro_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ro_measure_ctrl
// Description : Ring-oscillator measurement sequencer. Serially loads the
//               oscillator configuration chain, selects the clock source,
//               releases the dividers, waits for settling, then counts
//               synchronised oscillator edges over a fixed clk window and
//               holds the count for readout.
// Revision    : 1.0 - initial release
// ============================================================================
module ro_measure_ctrl #(
  parameter int CFG_BITS   = 48,
  parameter int WIN_LOG2   = 10,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,        // active-high despite the name
  input  logic                start,
  input  logic                abort,
  input  logic [CFG_BITS-1:0] cfg_word,
  input  logic [2:0]          src_sel,
  input  logic                osc_in,
  output logic                shift_clk,
  output logic                shift_dta,
  output logic [2:0]          clk_source,
  output logic                osc_rst,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    result,
  output logic                result_valid,
  output logic                overflow
);

  localparam int IDX_W = (CFG_BITS > 1)   ? $clog2(CFG_BITS)   : 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [IDX_W-1:0]    C_IDX_LAST = IDX_W'(CFG_BITS - 1);
  localparam logic [SET_W-1:0]    C_SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [WIN_LOG2-1:0] C_WIN_LAST = '1;
  localparam logic [CNT_W-1:0]    C_CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  logic [CFG_BITS-1:0] r_cfg;      // remaining bits, next bit to send at MSB
  logic [2:0]          r_src;
  logic [IDX_W-1:0]    r_idx;      // bit currently presented on shift_dta
  logic                r_phase;    // 0: data setup (shift_clk low), 1: clock high
  logic [SET_W-1:0]    r_set_cnt;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;

  logic                r_sync1;
  logic                r_sync2;
  logic                r_prev;

  logic                w_edge;
  logic                w_sat;
  logic                w_in_run;
  logic [CNT_W-1:0]    w_cnt_next;

  // Rising edge of the synchronised oscillator; counter saturates instead of wrapping
  always_comb begin
    w_edge     = r_sync2 & ~r_prev;
    w_sat      = (r_edge_cnt == C_CNT_MAX);
    w_cnt_next = (w_edge && !w_sat) ? (r_edge_cnt + CNT_W'(1)) : r_edge_cnt;
    w_in_run   = (r_state == S_LOAD) || (r_state == S_SETTLE) ||
                 (r_state == S_MEASURE);
  end

  // Free-running two-flop synchroniser plus previous-sample flop for osc_in
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= osc_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Sequencer state machine with all outputs registered
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state      <= S_IDLE;
      r_cfg        <= '0;
      r_src        <= 3'b000;
      r_idx        <= '0;
      r_phase      <= 1'b0;
      r_set_cnt    <= '0;
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      shift_clk    <= 1'b0;
      shift_dta    <= 1'b0;
      clk_source   <= 3'b000;
      osc_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && w_in_run) begin
        // Cancel: park the datapath and throw the partial measurement away
        r_state      <= S_IDLE;
        shift_clk    <= 1'b0;
        osc_rst      <= 1'b1;
        clk_source   <= 3'b000;
        busy         <= 1'b0;
        result_valid <= 1'b0;
        r_edge_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (abort) begin
              result_valid <= 1'b0;
            end else if (start) begin
              r_state      <= S_LOAD;
              r_src        <= src_sel;
              r_cfg        <= cfg_word << 1;
              shift_dta    <= cfg_word[CFG_BITS-1];
              shift_clk    <= 1'b0;
              r_idx        <= C_IDX_LAST;
              r_phase      <= 1'b0;
              clk_source   <= 3'b000;
              osc_rst      <= 1'b1;
              busy         <= 1'b1;
              result_valid <= 1'b0;
              overflow     <= 1'b0;
              r_edge_cnt   <= '0;
            end
          end

          S_LOAD: begin
            if (!r_phase) begin
              shift_clk <= 1'b1;
              r_phase   <= 1'b1;
            end else begin
              shift_clk <= 1'b0;
              r_phase   <= 1'b0;
              if (r_idx == '0) begin
                // Chain loaded: select the source and release the dividers
                r_state    <= S_SETTLE;
                clk_source <= r_src;
                osc_rst    <= 1'b0;
                r_set_cnt  <= '0;
              end else begin
                r_idx     <= r_idx - 1'b1;
                shift_dta <= r_cfg[CFG_BITS-1];
                r_cfg     <= r_cfg << 1;
              end
            end
          end

          S_SETTLE: begin
            if (r_set_cnt == C_SET_LAST) begin
              r_state    <= S_MEASURE;
              r_win_cnt  <= '0;
              r_edge_cnt <= '0;
            end else begin
              r_set_cnt <= r_set_cnt + 1'b1;
            end
          end

          S_MEASURE: begin
            r_edge_cnt <= w_cnt_next;
            // An edge arriving at full scale is a lost edge
            if (w_edge && w_sat) begin
              overflow <= 1'b1;
            end
            if (r_win_cnt == C_WIN_LAST) begin
              // Last window cycle still counts its edge into the result
              r_state      <= S_DONE;
              result       <= w_cnt_next;
              result_valid <= 1'b1;
              done         <= 1'b1;
              busy         <= 1'b0;
              osc_rst      <= 1'b1;
            end else begin
              r_win_cnt <= r_win_cnt + 1'b1;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ro_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_measure_ctrl
// Description : Directed self-checking bench for ro_measure_ctrl (default
//               parameters plus a CNT_W=4 instance for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_measure_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [47:0] cfg_word = '0;
  logic [2:0]  src_sel = 3'b000;
  logic        osc_a = 1'b0;
  logic        shift_clk, shift_dta, osc_rst, busy, done, result_valid, overflow;
  logic [2:0]  clk_source;
  logic [15:0] result;

  logic        start4 = 1'b0;
  logic        abort4 = 1'b0;
  logic [47:0] cfg4 = 48'h0000_0000_0001;
  logic [2:0]  src4 = 3'b010;
  logic        osc_b = 1'b0;
  logic        shift_clk4, shift_dta4, osc_rst4, busy4, done4, result_valid4, overflow4;
  logic [2:0]  clk_source4;
  logic [3:0]  result4;

  int checks = 0;
  int errors = 0;

  // clk period 10 (rising at 5+10k); oscillators toggle on multiples of 20,
  // so they never coincide with a rising clk edge
  always #5  clk   = ~clk;
  always #40 osc_a = ~osc_a;   // period 8 clk
  always #20 osc_b = ~osc_b;   // period 4 clk

  ro_measure_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_word(cfg_word), .src_sel(src_sel), .osc_in(osc_a),
    .shift_clk(shift_clk), .shift_dta(shift_dta), .clk_source(clk_source),
    .osc_rst(osc_rst), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid), .overflow(overflow)
  );

  ro_measure_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .cfg_word(cfg4), .src_sel(src4), .osc_in(osc_b),
    .shift_clk(shift_clk4), .shift_dta(shift_dta4), .clk_source(clk_source4),
    .osc_rst(osc_rst4), .busy(busy4), .done(done4), .result(result4),
    .result_valid(result_valid4), .overflow(overflow4)
  );

  // Model of the external configuration chain
  logic [47:0] chain = '0;
  int          rises = 0;
  always @(posedge shift_clk) begin
    chain <= {chain[46:0], shift_dta};
    rises <= rises + 1;
  end

  // Count done pulses, sampled mid-cycle
  int done_seen = 0;
  always @(negedge clk) begin
    if (done) done_seen <= done_seen + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Ticks until done (bounded); n counts clk edges since the accepting edge
  task automatic run_to_done(input int n0, input int repulse, output int n);
    n = n0;
    while (n < 3000) begin
      tick();
      n++;
      if (done) break;
      start = (n == repulse);
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_shift_clk"},    shift_clk,    1'b0);
    check({tag, "_shift_dta"},    shift_dta,    1'b0);
    check({tag, "_clk_source"},   clk_source,   3'b000);
    check({tag, "_osc_rst"},      osc_rst,      1'b1);
    check({tag, "_busy"},         busy,         1'b0);
    check({tag, "_done"},         done,         1'b0);
    check({tag, "_result"},       result,       16'd0);
    check({tag, "_result_valid"}, result_valid, 1'b0);
    check({tag, "_overflow"},     overflow,     1'b0);
  endtask

  int  n;
  int  rises0;
  int  load_bad;
  int  done0;
  logic osc_rst_pre;

  initial begin
    // ---------------- reset ----------------
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b0;
    repeat (2) tick();

    // ---------------- config load + full run with start re-pulses ----------------
    cfg_word = 48'hA5A5_0000_00FF;
    src_sel  = 3'b001;
    rises0   = rises;
    load_bad = 0;
    start    = 1'b1;
    tick();                       // accepting edge
    start    = 1'b0;
    check("load_busy",      busy,      1'b1);
    check("load_first_clk", shift_clk, 1'b0);
    check("load_first_dta", shift_dta, 1'b1);
    for (int i = 1; i <= 96; i++) begin
      if (clk_source !== 3'b000 || osc_rst !== 1'b1) load_bad++;
      if (i == 96) osc_rst_pre = osc_rst;
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    check("load_src_rst_held", load_bad,       0);
    check("load_last_osc_rst", osc_rst_pre,    1'b1);
    check("chain_content",     chain,          48'hA5A5_0000_00FF);
    check("shift_clk_rises",   rises - rises0, 48);
    check("settle_shift_clk",  shift_clk,      1'b0);
    check("settle_osc_rst",    osc_rst,        1'b0);
    check("settle_clk_source", clk_source,     3'b001);

    done0 = done_seen;
    run_to_done(96, 500, n);
    check("latency",          n,                                   1136);
    check("result_range",     (result >= 16'd127 && result <= 16'd129), 1'b1);
    check("overflow_clear",   overflow,     1'b0);
    check("result_valid",     result_valid, 1'b1);
    check("done_busy",        busy,         1'b0);
    check("done_osc_rst",     osc_rst,      1'b1);
    check("done_clk_src_hold", clk_source,  3'b001);
    tick();
    check("done_one_cycle",   done,         1'b0);
    check("valid_holds",      result_valid, 1'b1);
    check("single_done",      done_seen - done0, 1);

    // ---------------- start in DONE, then abort at LOAD bit 20 ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_valid_clr", result_valid, 1'b0);
    check("restart_busy",      busy,         1'b1);
    repeat (40) tick();
    done0 = done_seen;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",       busy,       1'b0);
    check("abort_shift_clk",  shift_clk,  1'b0);
    check("abort_osc_rst",    osc_rst,    1'b1);
    check("abort_clk_source", clk_source, 3'b000);
    check("abort_valid",      result_valid, 1'b0);
    repeat (5) tick();
    check("abort_no_done",    done_seen - done0, 0);

    // abort together with start in IDLE: stays idle
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_busy",    busy,      1'b0);
    repeat (3) tick();
    check("abort_start_idle",    busy,      1'b0);
    check("abort_start_osc_rst", osc_rst,   1'b1);

    // ---------------- asynchronous reset mid-MEASURE ----------------
    cfg_word = 48'h1234_5678_9ABC;
    src_sel  = 3'b101;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (300) tick();
    check("pre_reset_src",  clk_source, 3'b101);
    check("pre_reset_busy", busy,       1'b1);
    #2 rst_n = 1'b1;              // mid-cycle, away from any clk edge
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check("post_reset_idle", busy, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(0, -1, n);
    check("clean_latency",   n, 1136);
    check("clean_range",     (result >= 16'd127 && result <= 16'd129), 1'b1);
    check("clean_overflow",  overflow,     1'b0);
    check("clean_valid",     result_valid, 1'b1);

    // ---------------- CNT_W=4 saturation ----------------
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (n < 3000 && !done4) begin
      tick();
      n++;
    end
    check("sat_latency",  n,             1136);
    check("sat_result",   result4,       4'd15);
    check("sat_overflow", overflow4,     1'b1);
    check("sat_valid",    result_valid4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ro_measure_ctrl.md
Name: ro_measure_ctrl

Overview:
- Sequencer for the ring-oscillator experiment: serially loads the 48-bit oscillator configuration chain, selects the clock source and releases the oscillator dividers.
- It then counts oscillator edges over a fixed window of system clocks and holds the result for readout.
- Sits between the host-side command logic and the oscillator/config-chain/clock-selector datapath. Replaces manual bit-banging of shift_clk/shift_dta.

Parameters:
- CFG_BITS, 48, length of the configuration shift chain in bits.
- WIN_LOG2, 10, measurement window = 2^WIN_LOG2 clk cycles.
- SETTLE_CYC, 16, clk cycles between divider release and window start.
- CNT_W, 16, edge-counter/result width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-high (name notwithstanding).
- start  in  1  request a measurement; sampled only in IDLE.
- abort  in  1  cancel any in-progress measurement.
- cfg_word  in  CFG_BITS  oscillator configuration; latched on accepted start.
- src_sel  in  3  clock-source code; latched on accepted start.
- osc_in  in  1  selected oscillator (divided) clock, asynchronous to clk.
- shift_clk  out  1  config-chain shift clock (registered).
- shift_dta  out  1  config-chain serial data (registered).
- clk_source  out  3  clock-selector code to the datapath.
- osc_rst  out  1  active-high reset to the oscillator dividers.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  one-cycle pulse on entry to DONE.
- result  out  CNT_W  edge count of last completed window.
- result_valid  out  1  result holds a completed measurement.
- overflow  out  1  edge counter saturated during last window.

Behaviour:
- Reset values: shift_clk=0, shift_dta=0, clk_source=3'b000, osc_rst=1, busy=0, done=0, result=0, result_valid=0, overflow=0; state=IDLE.
- States:
  - IDLE: waits for start.
  - LOAD: shifts the configuration word into the chain.
  - SETTLE: waits SETTLE_CYC cycles for the oscillator to settle.
  - MEASURE: counts oscillator edges for 2^WIN_LOG2 cycles.
  - DONE: holds the result.
- IDLE→LOAD: start=1 and abort=0. Latches cfg_word and src_sel, clears result_valid and overflow, zeroes the edge counter, bit index=CFG_BITS-1.
- DONE behaves as IDLE for start, except result_valid stays 1 until a new start is accepted.
- LOAD: 2 cycles per bit, MSB first.
  - Phase A: shift_dta=cfg[idx], shift_clk=0.
  - Phase B: shift_clk=1, shift_dta held.
  - After CFG_BITS bits, the chain holds shifter[i]=cfg_word[i].
  - Final phase B is followed by shift_clk=0 on entry to SETTLE. LOAD lasts exactly 2*CFG_BITS cycles.
  - clk_source=3'b000 and osc_rst=1 throughout LOAD.
- SETTLE: on entry, clk_source=latched src_sel and osc_rst=0. Lasts SETTLE_CYC cycles, then goes to MEASURE.
- MEASURE: lasts exactly 2^WIN_LOG2 cycles.
  - osc_in passes through a 2-flop synchronizer plus a previous-sample flop. These run continuously in every state.
  - Each cycle with sync=1 and prev=0 increments the counter.
  - The counter saturates at 2^CNT_W-1 and sets overflow (sticky for the window).
  - Usable osc_in frequency is below clk/2. Faster inputs under-count and are not flagged.
- MEASURE→DONE: result=final count, result_valid=1, done=1 for one cycle, osc_rst=1, clk_source held.
- Latency, accepted start to done: 2*CFG_BITS + SETTLE_CYC + 2^WIN_LOG2 + 1 cycles.
- start while busy=1: ignored, not queued.
- abort=1 in LOAD/SETTLE/MEASURE: next state IDLE.
  - shift_clk=0, osc_rst=1, clk_source=3'b000.
  - result_valid=0, done not pulsed, counter discarded.
  - The chain content is partially shifted and undefined.
- abort in IDLE/DONE: clears result_valid only. abort and start in the same cycle: abort wins.
- rst_n asserted mid-operation: all outputs return to reset values immediately (asynchronous). After release, the controller sits in IDLE.

Test Plan:
- Reset, then start with cfg_word=48'hA5A5_0000_00FF, src_sel=3'b001. A bench shift-register model clocked by shift_clk must read 48'hA5A5_0000_00FF after exactly 96 cycles. shift_clk shows 48 rising edges; clk_source=000 and osc_rst=1 during LOAD.
- Full run, osc_in period 8 clk (defaults): result=128 (±1 for phase), overflow=0. done pulses exactly 1+96+16+1024 cycles after start; busy=0 afterwards.
- CNT_W=4 override, osc_in period 4 clk: counter saturates, result=15, overflow=1, result_valid=1.
- Start re-pulsed at cycles 10 and 500 of a run: no effect on timing or result. A start in DONE begins a new run and clears result_valid on the next cycle.
- abort at LOAD bit 20: IDLE next cycle, shift_clk=0, osc_rst=1, result_valid=0, no done pulse. Repeat with abort+start together in IDLE: stays IDLE.
- rst_n pulsed mid-MEASURE, asynchronous to clk: outputs reach reset values before the next clk edge. A following start runs a clean full measurement.
